// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Purpose
//   Receives an instruction image from a byte-wide host link and writes it into
//   a 16-bit-wide instruction memory. The processor pipeline is held in reset
//   while a session is running.
//
//   Byte stream of one session (after a start pulse):
//     LEN_HI LEN_LO                 16-bit word count, high byte first
//     { DAT_HI DAT_LO } x count     one instruction word each, high byte first
//     [ CHK ]                       XOR of all data bytes (checksum build only)
//
//   Words whose address is at or above the memory capacity (1<<N) are still
//   consumed from the link but not written; they set the sticky err flag.
//
// Build option
//   IMEM_LOADER_CHECKSUM_EN  when defined, a running XOR of the data bytes is
//                            kept and one trailing checksum byte is compared
//                            against it; a difference sets err. When undefined
//                            the checksum state and logic are not built and err
//                            reports address overflow only.
//
// Parameters
//   N             instruction memory address width (capacity 1<<N words), N>=2
//
// Ports
//   clk           system clock, rising edge
//   rst           asynchronous reset, active low
//   start         one-cycle pulse, begins a session when idle
//   in_data[7:0]  byte from host link
//   in_valid      in_data holds a byte
//   in_ready      loader accepts a byte (transfer when in_valid & in_ready)
//   write_enable  instruction memory write strobe
//   write_addr    instruction memory word address (upper 32-N bits zero)
//   write_data    instruction word to write
//   busy          session in progress
//   done          one-cycle pulse at end of session
//   err           sticky error flag, cleared by the next accepted start
//   cpu_hold      keeps the processor pipeline in reset while high
//
//   Every output comes straight from a flop.
// -----------------------------------------------------------------------------
module imem_loader #(
  parameter int N = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        write_enable,
  output logic [31:0] write_addr,
  output logic [15:0] write_data,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        cpu_hold
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_HI = 3'd1,
    LEN_LO = 3'd2,
    DAT_HI = 3'd3,
    DAT_LO = 3'd4,
    WRITE  = 3'd5,
`ifdef IMEM_LOADER_CHECKSUM_EN
    CHK    = 3'd6,
`endif
    FIN    = 3'd7
  } state_t;

  // State entered once the last data word (or a zero count) has been handled.
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t END_STATE = CHK;
`else
  localparam state_t END_STATE = FIN;
`endif

  localparam logic [N-1:0] ADDR_ONE = {{(N-1){1'b0}}, 1'b1};

  state_t         state_q,     state_d;
  logic [N-1:0]   addr_q,      addr_d;      // current word address (wraps)
  logic           oflow_q,     oflow_d;     // address counter has passed 1<<N
  logic [15:0]    rem_q,       rem_d;       // words still to be received
  logic [15:0]    wdata_q,     wdata_d;
  logic           err_q,       err_d;
  logic           in_ready_q,  in_ready_d;
  logic           we_q,        we_d;
  logic           busy_q,      busy_d;
  logic           done_q,      done_d;
  logic           hold_q,      hold_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]     xor_q,       xor_d;
`endif

  logic           accept;

  // Handshake is judged on the registered in_ready that the host also sees.
  assign accept = in_ready_q & in_valid;

  // ---------------------------------------------------------------------------
  // Next-state and datapath updates
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    oflow_d = oflow_q;
    rem_d   = rem_q;
    wdata_d = wdata_q;
    err_d   = err_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    xor_d   = xor_q;
`endif

    unique case (state_q)
      IDLE: begin
        // start is only honoured here, so a pulse during a session is ignored.
        if (start) begin
          state_d = LEN_HI;
          err_d   = 1'b0;
          addr_d  = '0;
          oflow_d = 1'b0;
          rem_d   = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          xor_d   = '0;
`endif
        end
      end

      LEN_HI: begin
        if (accept) begin
          rem_d[15:8] = in_data;
          state_d     = LEN_LO;
        end
      end

      LEN_LO: begin
        if (accept) begin
          rem_d[7:0] = in_data;
          if ({rem_q[15:8], in_data} == 16'd0) begin
            state_d = END_STATE;
          end else begin
            state_d = DAT_HI;
          end
        end
      end

      DAT_HI: begin
        if (accept) begin
          wdata_d[15:8] = in_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
          xor_d         = xor_q ^ in_data;
`endif
          state_d       = DAT_LO;
        end
      end

      DAT_LO: begin
        if (accept) begin
          wdata_d[7:0] = in_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
          xor_d        = xor_q ^ in_data;
`endif
          state_d      = WRITE;
        end
      end

      WRITE: begin
        // The strobe for this word was suppressed already if oflow_q is set.
        if (oflow_q) begin
          err_d = 1'b0 | 1'b1;
        end
        // Carry out of the N-bit counter means every later word is beyond
        // the memory; remember that rather than widening the counter.
        if (&addr_q) begin
          oflow_d = 1'b1;
        end
        addr_d = addr_q + ADDR_ONE;
        rem_d  = rem_q - 16'd1;
        if (rem_q == 16'd1) begin
          state_d = END_STATE;
        end else begin
          state_d = DAT_HI;
        end
      end

`ifdef IMEM_LOADER_CHECKSUM_EN
      CHK: begin
        if (accept) begin
          if (in_data != xor_q) begin
            err_d = 1'b1;
          end
          state_d = FIN;
        end
      end
`endif

      FIN: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output flops are loaded from the next state so they line up with state_q
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready_d = 1'b0;
    we_d       = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    hold_d     = 1'b0;

    unique case (state_d)
      LEN_HI, LEN_LO, DAT_HI, DAT_LO: in_ready_d = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHK:                            in_ready_d = 1'b1;
`endif
      default:                        in_ready_d = 1'b0;
    endcase

    // Entering WRITE never changes the address or overflow flag, so the
    // next-cycle values are the ones that apply during WRITE.
    we_d   = (state_d == WRITE) && !oflow_d;
    busy_d = (state_d != IDLE);
    hold_d = (state_d != IDLE);
    done_d = (state_d == FIN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      oflow_q    <= 1'b0;
      rem_q      <= '0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
      in_ready_q <= 1'b0;
      we_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      hold_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      oflow_q    <= oflow_d;
      rem_q      <= rem_d;
      wdata_q    <= wdata_d;
      err_q      <= err_d;
      in_ready_q <= in_ready_d;
      we_q       <= we_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      hold_q     <= hold_d;
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      xor_q <= '0;
    end else begin
      xor_q <= xor_d;
    end
  end
`endif

  // addr_q only moves on leaving WRITE, so the address is steady while the
  // strobe is high; write_data likewise only changes in DAT_HI/DAT_LO.
  assign in_ready     = in_ready_q;
  assign write_enable = we_q;
  assign write_addr   = 32'(addr_q);
  assign write_data   = wdata_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign cpu_hold     = hold_q;

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter: N, default 6, instruction memory address width; capacity is 1<<N 16-bit words.
REQ-002 clk  input  1  system clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  one-cycle pulse that begins a load session.
REQ-005 in_data  input  8  byte stream from the host link.
REQ-006 in_valid  input  1  in_data holds a valid byte.
REQ-007 in_ready  output  1  loader accepts a byte; transfer occurs on a posedge where in_valid and in_ready are both 1.
REQ-008 write_enable  output  1  instruction memory write strobe.
REQ-009 write_addr  output  32  instruction memory word address; upper 32-N bits are always 0.
REQ-010 write_data  output  16  instruction word to write.
REQ-011 busy  output  1  session in progress.
REQ-012 done  output  1  one-cycle pulse at session end.
REQ-013 err  output  1  sticky error flag, cleared by the next start.
REQ-014 cpu_hold  output  1  holds the pipeline in reset while 1.

Function
REQ-015 States SHALL be IDLE, LEN_HI, LEN_LO, DAT_HI, DAT_LO, WRITE, CHK, FIN.
REQ-016 IDLE: in_ready=0, busy=0; on start go to LEN_HI, clear err, reset the address counter to 0.
REQ-017 LEN_HI/LEN_LO: accept two bytes, high byte first, forming a 16-bit word count.
REQ-018 A count of 0 SHALL go from LEN_LO to CHK with the macro enabled, or to FIN with it disabled.
REQ-019 DAT_HI/DAT_LO: accept two bytes, high first, assembled into write_data[15:8]/[7:0].
REQ-020 WRITE lasts exactly one cycle: in_ready=0, write_enable=1, write_addr=current counter.
REQ-021 After WRITE: increment the counter and decrement the remaining count; go to DAT_HI if the remaining count is nonzero, else to CHK or FIN.
REQ-022 Overflow: words at counter >= 1<<N SHALL still be consumed, with write_enable held at 0, and SHALL set err.
REQ-023 FIN lasts one cycle: done=1, then go to IDLE.
REQ-024 cpu_hold SHALL be 1 from the cycle after start through FIN inclusive, and 0 otherwise.
REQ-025 A start pulse while busy=1 SHALL be ignored.
REQ-026 in_ready SHALL be 1 only in LEN_HI, LEN_LO, DAT_HI, DAT_LO and CHK; bytes offered in other states SHALL be left unconsumed.
REQ-027 Stalls: a state with in_ready=1 SHALL hold indefinitely while in_valid=0.
REQ-028 All outputs SHALL be registered; write_data and write_addr SHALL be stable whenever write_enable=1.

Reset
REQ-029 When rst=0: state=IDLE, counters=0, and in_ready, write_enable, write_addr, write_data, busy, done, err and cpu_hold all =0, immediately and without waiting for clk.
REQ-030 A reset mid-session SHALL abort the session; no further writes occur after rst is released until a new start.

Configuration
REQ-031 Macro IMEM_LOADER_CHECKSUM_EN, when defined: the loader SHALL keep a running XOR of all data bytes (length bytes excluded).
REQ-032 With the macro defined: CHK accepts one byte; err is set if that byte differs from the XOR; then go to FIN.
REQ-033 With the macro undefined: the CHK state and the XOR logic are absent, and err is driven by overflow only.

Verification
REQ-034 rst=0 asserted mid-WRITE -> all outputs 0 in the same cycle; after release, state IDLE and no write_enable.
REQ-035 start, bytes 00 02 12 34 AB CD (+ checksum 0x40 if the macro is enabled) -> writes 0x1234@0 and 0xABCD@1, done pulse, err=0.
REQ-036 start, count 0x0000 (+ checksum 0x00 if the macro is enabled) -> no writes, done pulse after 2 (or 3) accepted bytes.
REQ-037 N=2, count 5 -> writes at addresses 0-3 only, 5th word consumed, err=1 at done.
REQ-038 Macro enabled, data 12 34 with checksum 0x00 -> err=1; in_valid toggled randomly -> the same writes occur and no byte is lost.
